// File: rtl/ysyx_22050133_regfile_sb_if.sv
// rtl/ysyx_22050133_regfile_sb_if.sv - write-back, read and issue bus of the scoreboarded register file
interface ysyx_22050133_regfile_sb_if #(
  parameter int DATA_WIDTH = 64,
  parameter int AW         = 5,
  parameter int NREAD      = 2
);
  logic                        ready;
  logic                        busy_any;
  logic                        wen0;
  logic [AW-1:0]               rd0;
  logic [DATA_WIDTH-1:0]       rddata0;
  logic                        wen1;
  logic [AW-1:0]               rd1;
  logic [DATA_WIDTH-1:0]       rddata1;
  logic [NREAD*AW-1:0]         rs;
  logic [NREAD*DATA_WIDTH-1:0] rsdata;
  logic                        iss_valid;
  logic [AW-1:0]               iss_rd;
  logic [AW-1:0]               iss_rs1;
  logic [AW-1:0]               iss_rs2;
  logic                        hazard;

  modport master (
    input  ready, busy_any, rsdata, hazard,
    output wen0, rd0, rddata0, wen1, rd1, rddata1, rs,
    output iss_valid, iss_rd, iss_rs1, iss_rs2
  );

  modport slave (
    output ready, busy_any, rsdata, hazard,
    input  wen0, rd0, rddata0, wen1, rd1, rddata1, rs,
    input  iss_valid, iss_rd, iss_rs1, iss_rs2
  );
endinterface

// File: rtl/ysyx_22050133_regfile_sb.sv
// rtl/ysyx_22050133_regfile_sb.sv - register file with busy scoreboard and clear engine (option: YSYX_22050133_BYPASS_EN)
module ysyx_22050133_regfile_sb #(
  parameter int DATA_WIDTH = 64,
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int NREAD      = 2
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_22050133_regfile_sb_if.slave bus
);

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  logic [AW-1:0]         cnt;
  logic                  ready_q;
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic [NREG-1:0]       clr;
  logic [NREG-1:0]       blk;
  logic [DATA_WIDTH-1:0] rf [NREG];

  logic                  act;
  logic                  we0;
  logic                  we1;
  logic                  accept;
  logic                  hazard_c;
  logic [AW-1:0]         ridx;
  logic [DATA_WIDTH-1:0] rval;
  logic [NREAD*DATA_WIDTH-1:0] rsdata_c;

  assign act = (state == READY);
  assign we0 = act && bus.wen0 && (bus.rd0 != '0);
  assign we1 = act && bus.wen1 && (bus.rd1 != '0);

  // Clear engine: walk cnt over every register, then settle in READY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(NREG - 1)) begin
            state   <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          state <= READY;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Storage array carries no reset so it can map onto RAM cells; port 0 wins a same-index collision
  always_ff @(posedge clk) begin
    if (!act) begin
      rf[cnt] <= '0;
    end else begin
      if (we1 && !(we0 && (bus.rd0 == bus.rd1))) rf[bus.rd1] <= bus.rddata1;
      if (we0) rf[bus.rd0] <= bus.rddata0;
    end
  end

  // Per-register write-back hit vector, shared by scoreboard clear and hazard masking
  always_comb begin
    clr = '0;
    for (int r = 1; r < NREG; r++) begin
      clr[r] = (we0 && (bus.rd0 == AW'(r))) || (we1 && (bus.rd1 == AW'(r)));
    end
  end

`ifdef YSYX_22050133_BYPASS_EN
  assign blk = busy & ~clr;
`else
  assign blk = busy;
`endif

  // Hazard detection: RAW on either source, WAW on the destination; everything stalls while clearing
  always_comb begin
    hazard_c = bus.iss_valid;
    if (act) begin
      hazard_c = bus.iss_valid && ((blk[bus.iss_rs1] && (bus.iss_rs1 != '0)) ||
                                   (blk[bus.iss_rs2] && (bus.iss_rs2 != '0)) ||
                                   blk[bus.iss_rd]);
    end
  end

  assign accept = bus.iss_valid && act && !hazard_c && (bus.iss_rd != '0);

  // Scoreboard next state: write-back clears, a new issue sets and overrides a same-cycle clear
  always_comb begin
    busy_nxt = busy & ~clr;
    if (accept) busy_nxt[bus.iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Busy bits only evolve once the array is usable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (act) begin
      busy <= busy_nxt;
    end
  end

  // Combinational read ports: zero during clearing and for index 0
  always_comb begin
    rsdata_c = '0;
    ridx     = '0;
    rval     = '0;
    for (int k = 0; k < NREAD; k++) begin
      ridx = bus.rs[k*AW +: AW];
      rval = '0;
      if (act && (ridx != '0)) begin
        rval = rf[ridx];
`ifdef YSYX_22050133_BYPASS_EN
        if (we1 && (bus.rd1 == ridx)) rval = bus.rddata1;
        if (we0 && (bus.rd0 == ridx)) rval = bus.rddata0;
`endif
      end
      rsdata_c[k*DATA_WIDTH +: DATA_WIDTH] = rval;
    end
  end

  assign bus.rsdata   = rsdata_c;
  assign bus.hazard   = hazard_c;
  assign bus.ready    = ready_q;
  assign bus.busy_any = |busy;

endmodule

// File: doc/ysyx_22050133_regfile_sb.md
# ysyx_22050133_regfile_sb

Parametrised integer register file with multi-port reads, two prioritised write-back ports, a per-register busy scoreboard and a post-reset sequential clear engine. It sits between decode/issue and write-back in the ysyx_22050133 core. It supplies operands to NREAD read ports and flags RAW and WAW hazards to the issue stage. The storage array has no reset fan-out, so it maps to RAM-style cells.

## Interface
Parameters:
- DATA_WIDTH, 64, register width in bits
- NREG, 32, number of architectural registers (power of two, at least 2)
- AW, 5, register index width (log2(NREG))
- NREAD, 2, number of read ports

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous and active-high
- ready  out  1  high once the clear sequence is complete
- busy_any  out  1  OR of all busy bits
- wen0  in  1  write enable, port 0 (ALU write-back, higher priority)
- rd0  in  AW  destination index, port 0
- rddata0  in  DATA_WIDTH  write data, port 0
- wen1  in  1  write enable, port 1 (LSU/multi-cycle write-back)
- rd1  in  AW  destination index, port 1
- rddata1  in  DATA_WIDTH  write data, port 1
- rs  in  NREAD*AW  packed read indices; port k is at [k*AW +: AW]
- rsdata  out  NREAD*DATA_WIDTH  packed read data
- iss_valid  in  1  issue request
- iss_rd  in  AW  destination of the issuing instruction (0 = no destination)
- iss_rs1  in  AW  source 1 of the issuing instruction
- iss_rs2  in  AW  source 2 of the issuing instruction
- hazard  out  1  issue must stall this cycle

## Operation
- **FSM states INIT and READY.**
  - rst asserted: state=INIT, clear counter cnt=0, all busy bits=0, ready=0.
  - In INIT, each cycle writes rf[cnt]=0 and increments cnt. The cycle that writes rf[NREG-1] transitions to READY.
  - rst asserted at any point, including in READY, returns the block to INIT with cnt=0.
- **INIT behaviour.**
  - wen0/wen1 are ignored.
  - Issue is ignored; hazard = iss_valid.
  - All rsdata read 0.
- **Writes (READY only).**
  - wen & rd!=0 writes rd at the clock edge. Writes to register 0 are discarded.
  - wen0 and wen1 to the same rd in the same cycle: port 0 data is stored.
- **Reads.**
  - Combinational.
  - Index 0 returns 0.
  - Otherwise returns rf[index], or bypassed data (see Configuration).
- **Scoreboard.**
  - Each busy[r] bit is cleared by an accepted write to r on either port.
  - An accepted issue (iss_valid & ready & !hazard & iss_rd!=0) sets busy[iss_rd].
  - Set and clear of the same register in one cycle: set wins, because a new producer has been issued.
  - busy[0] is constant 0.
- **Hazard.**
  - hazard = iss_valid & (src1_block | src2_block | dst_block).
  - src_block for a source register = busy[src] & src!=0.
  - dst_block = busy[iss_rd] (WAW).
  - Clearance by a same-cycle write is governed by the Configuration macro.

## Timing
- Reset values: ready=0, busy_any=0, rsdata=0, hazard=iss_valid.
- ready rises on the NREG-th rising clk edge after rst deasserts. With defaults, ready is high after 32 edges.
- A write reaches the array at the clk edge. Without bypass, it is visible on rsdata in the following cycle.
- A busy bit set at edge N raises hazard for dependent issues from cycle N+1 onward.
- No read latency; hazard is combinational from the iss_* inputs and busy state.

## Configuration
- YSYX_22050133_BYPASS_EN defined:
  - A read whose index matches an enabled write port this cycle returns that port's data. Port 0 has priority over port 1.
  - A busy register being written this cycle does not raise hazard.
- YSYX_22050133_BYPASS_EN undefined:
  - Reads return array contents only.
  - A busy register still raises hazard in its write-back cycle and is clear from the next cycle.

## Test plan
- Reset, then preload rf[5] with a nonzero value, then pulse rst for 1 cycle with clk running:
  - ready=0 for 32 edges, then 1.
  - All 32 registers then read 0, including rf[5].
- READY; wen0=1, rd0=7, rddata0=0xDEAD; rs[0]=7:
  - Bypass build: rsdata[0]=0xDEAD in the same cycle.
  - Non-bypass build: rsdata[0]=0xDEAD only in the next cycle.
- wen0 rd0=3 data 0x11, and wen1 rd1=3 data 0x22, in the same cycle -> rf[3]=0x11. Write of 0xFF to register 0 -> reads 0.
- Issue iss_rd=9 accepted, then issue iss_rs1=9 -> hazard=1. Then wen1 rd1=9:
  - Bypass build: hazard=0 in the write cycle.
  - Non-bypass build: hazard=1 in the write cycle and 0 in the cycle after.
  - busy_any returns to 0.
- Same-cycle wen0 rd0=4 and accepted issue iss_rd=4 -> busy[4]=1 afterwards. A following issue with iss_rs2=4 stalls.
- rst asserted mid-stream with busy bits set and writes pending:
  - busy_any=0, ready=0 and rsdata=0 immediately (asynchronously).
  - Clear sequence restarts from cnt=0.
